mult_booth: RTL

MULT_BOOTH -- requirements
Module: mult_booth

---
 rtl/mult_pkg.sv | 18 +
 rtl/booth_recoder.sv | 52 +++++
 rtl/mult_booth.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and enums for the radix-4 Booth multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 16;
  // The accumulator carries two guard bits so that +/-2M partial sums never wrap.
  localparam int ACC_W      = DATA_W + 2;
  // Product register layout: {acc[ACC_W-1:0], Q[DATA_W-1:0], q_minus1}.
  localparam int PROD_W     = ACC_W + DATA_W + 1;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {B_ZERO, B_PM, B_P2M, B_NM, B_N2M} booth_op_t;

endpackage

// File: rtl/booth_recoder.sv
// booth_recoder: radix-4 Booth digit decoder producing the accumulator addend.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_bits  - product bits [2:0] (two multiplier bits plus the previous bit)
//        i_mcand - sign-extended multiplicand
//        o_addend - M, 2M, ~M, ~2M or 0
//        o_cin   - carry-in completing the two's-complement negation in the adder
module booth_recoder
  import mult_pkg::*;
(
  input  logic [2:0]       i_bits,
  input  logic [ACC_W-1:0] i_mcand,
  output logic [ACC_W-1:0] o_addend,
  output logic             o_cin
);

  booth_op_t w_op;
  logic [ACC_W-1:0] w_mcand_x2;

  assign w_mcand_x2 = {i_mcand[ACC_W-2:0], 1'b0};

  always_comb begin
    w_op = B_ZERO;
    case (i_bits)
      3'b001, 3'b010: w_op = B_PM;
      3'b011:         w_op = B_P2M;
      3'b100:         w_op = B_N2M;
      3'b101, 3'b110: w_op = B_NM;
      default:        w_op = B_ZERO;
    endcase
  end

  // Negative digits hand back the inverted operand; the adder adds the +1.
  always_comb begin
    o_addend = '0;
    o_cin    = 1'b0;
    case (w_op)
      B_PM:  o_addend = i_mcand;
      B_P2M: o_addend = w_mcand_x2;
      B_NM: begin
        o_addend = ~i_mcand;
        o_cin    = 1'b1;
      end
      B_N2M: begin
        o_addend = ~w_mcand_x2;
        o_cin    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_booth.sv
// mult_booth: sequential radix-4 Booth 32x32 signed multiplier, low-32 result.
// Latency: start sampled at edge N, result_ready high for the cycle after edge N+17.
// Backpressure: none; ctrl_mult is ignored while RUN/DONE, accepted in IDLE only.
// Ports: clock, reset (sync, active-high), ctrl_mult (start), multiplicand, multiplier,
//        result, result_ready (1-cycle pulse), exception (signed overflow), busy (RUN).
// Build option: define MULT_OVERFLOW_EN to compute exception; otherwise it is tied 0.
module mult_booth
  import mult_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_mult,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic [DATA_W-1:0] result,
  output logic              result_ready,
  output logic              exception,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_mcand;
  logic [PROD_W-1:0]   r_prod;
  logic [DATA_W-1:0]   r_result;
  logic                r_result_ready;

  logic                w_last_iter;
  logic [ACC_W-1:0]    w_addend;
  logic                w_cin;
  logic [ACC_W-1:0]    w_sum;
  logic [PROD_W-1:0]   w_prod_nxt;

  assign w_last_iter = (r_cnt == CNT_W'(ITER_COUNT - 1));

  booth_recoder u_booth_recoder (
    .i_bits   (r_prod[2:0]),
    .i_mcand  (r_mcand),
    .o_addend (w_addend),
    .o_cin    (w_cin)
  );

  assign w_sum      = r_prod[PROD_W-1 -: ACC_W] + w_addend + {{(ACC_W-1){1'b0}}, w_cin};
  assign w_prod_nxt = $signed({w_sum, r_prod[PROD_W-ACC_W-1:0]}) >>> 2;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      IDLE: if (ctrl_mult) w_state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last_iter) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt          <= '0;
      r_mcand        <= '0;
      r_prod         <= '0;
      r_result       <= '0;
      r_result_ready <= 1'b0;
    end else begin
      r_result_ready <= 1'b0;
      case (r_state)
        IDLE: if (ctrl_mult) begin
          r_mcand <= {{(ACC_W-DATA_W){multiplicand[DATA_W-1]}}, multiplicand};
          r_prod  <= {{ACC_W{1'b0}}, multiplier, 1'b0};
          r_cnt   <= '0;
        end
        RUN: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          // Full 64-bit product lives in r_prod[64:1].
          r_result       <= r_prod[DATA_W:1];
          r_result_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign result_ready = r_result_ready;

`ifdef MULT_OVERFLOW_EN
  logic              r_exception;
  logic [DATA_W:0]   w_upper;

  // Product bits [63:31]; any disagreement means the value does not fit in 32 signed bits.
  assign w_upper = r_prod[2*DATA_W:DATA_W];

  always_ff @(posedge clock) begin
    if (reset)                r_exception <= 1'b0;
    else if (r_state == DONE) r_exception <= ~((&w_upper) | (~|w_upper));
  end

  assign exception = r_exception;
`else
  assign exception = 1'b0;
`endif

endmodule
